// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: branch-select encodings, fetch FSM states, default widths and
// opcode field position for the fetch unit and its next-PC logic.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int PC_W_DEF    = 8;
  localparam int OFF_W_DEF   = 6;

  // Opcode occupies the top OPC_W bits of the instruction register.
  localparam int OPC_W = 5;

  typedef enum logic [1:0] {
    BS_INC  = 2'b00,
    BS_COND = 2'b01,
    BS_JR   = 2'b10,
    BS_JMP  = 2'b11
  } bs_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_e;

  // Least significant bit of the opcode field for a given instruction width.
  function automatic int opc_lsb(input int instr_w);
    return instr_w - OPC_W;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory req/ack bus
// Purpose: groups the instruction memory handshake.
// Signals: imem_req (fetch request), imem_addr (fetch address),
//          imem_ack (data returned this cycle), imem_rdata (instruction word).
// Modports: master = fetch unit side, slave = memory side.
interface instruction_fetch_unit_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// rtl/instruction_fetch_unit_next_pc_logic.sv - combinational next program counter select
// Purpose: computes the PC that follows the executing instruction.
// Ports: pc (address of executing instruction), off (IR offset field),
//        bs/ps (branch select and polarity), zero (datapath flag),
//        ra_data (jump-register target), next_pc (result).
// All arithmetic wraps modulo 2^PC_W.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit_next_pc_logic #(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       bs,
  input  logic             ps,
  input  logic             zero,
  input  logic [PC_W-1:0]  ra_data,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic            cond_taken;

  assign offset_ext = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  assign pc_inc     = pc + PC_W'(1);
  // Relative targets are based on the executing instruction's own address.
  assign pc_rel     = pc + offset_ext;
  // Taken when zero is set and ps=0, or zero is clear and ps=1.
  assign cond_taken = ps ^ zero;

  // Unknown bs values fall through to the default increment.
  always_comb begin
    next_pc = pc_inc;
    case (bs)
      BS_INC:  next_pc = pc_inc;
      BS_COND: next_pc = cond_taken ? pc_rel : pc_inc;
      BS_JR:   next_pc = ra_data;
      BS_JMP:  next_pc = pc_rel;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, instruction register and fetch FSM
// Purpose: fetches instruction words over the req/ack bus, holds the
// instruction through execute and advances the PC from branch controls.
// Ports: clk, reset (async active-high), run (level enable),
//        imem (req/ack bus, master side), ir, opcode, exec_valid,
//        stall, bs, ps, zero, ra_data, pc.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int OFF_W   = OFF_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  instruction_fetch_unit_if.master   imem,
  output logic [INSTR_W-1:0]         ir,
  output logic [OPC_W-1:0]           opcode,
  output logic                       exec_valid,
  input  logic                       stall,
  input  logic [1:0]                 bs,
  input  logic                       ps,
  input  logic                       zero,
  input  logic [PC_W-1:0]            ra_data,
  output logic [PC_W-1:0]            pc
);

  state_e          state;
  logic            req_q;
  logic [PC_W-1:0] next_pc;

  assign imem.imem_req  = req_q;
  // pc only changes at the end of EXEC, so the address is stable for the whole fetch.
  assign imem.imem_addr = pc;
  assign opcode         = ir[opc_lsb(INSTR_W) +: OPC_W];

  instruction_fetch_unit_next_pc_logic #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_pc (
    .pc      (pc),
    .off     (ir[OFF_W-1:0]),
    .bs      (bs),
    .ps      (ps),
    .zero    (zero),
    .ra_data (ra_data),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= '0;
      ir         <= '0;
      req_q      <= 1'b0;
      exec_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_FETCH;
            req_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Acks are only honoured here, where req is always high; stray acks
          // in other states never reach ir.
          if (imem.imem_ack) begin
            ir         <= imem.imem_rdata;
            req_q      <= 1'b0;
            exec_valid <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc         <= next_pc;
            exec_valid <= 1'b0;
            // run is checked only here, so a fetch in flight always completes
            // and executes before the unit parks.
            if (run) begin
              state <= ST_FETCH;
              req_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_q      <= 1'b0;
          exec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
